// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - shared opcode and state types for the ALU / mul-div datapath
package alu_muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010
  } alu_op_t;

  // bit 1 selects divide, bit 0 selects signed
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand, ALU result and mul/div handshake bundle
interface alu_muldiv_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluop;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             md_start;
  logic [1:0]       md_op;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, aluop, shamt, md_start, md_op, mthi, mtlo,
    input  result, zero, busy, done, dbz, hi, lo
  );

  modport slave (
    input  a, b, aluop, shamt, md_start, md_op, mthi, mtlo,
    output result, zero, busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative one-bit-per-cycle multiply/divide with HI/LO registers
module muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state;
  md_state_t        state_next;
  md_op_t           op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] a_lat;
  logic             sa;
  logic             sb;

  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_t;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign busy      = (state != IDLE);
  assign last_step = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (md_start) state_next = RUN;
      RUN:     if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are reduced to magnitudes up front so RUN is always unsigned.
  always_comb begin
    a_mag    = (md_op[0] && a[WIDTH-1]) ? -a : a;
    b_mag    = (md_op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, ma} : '0);
    div_t    = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = (div_t >= {1'b0, mb});
    div_diff = div_t[WIDTH-1:0] - mb;
    prod     = {acc_hi, acc_lo};
    prod_fix = (op == MD_MULT && (sa ^ sb)) ? -prod : prod;
    quo_fix  = (op == MD_DIV && (sa ^ sb)) ? -acc_lo : acc_lo;
    rem_fix  = (op == MD_DIV && sa) ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op     <= MD_MULTU;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      ma     <= '0;
      mb     <= '0;
      a_lat  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            op     <= md_op_t'(md_op);
            count  <= '0;
            ma     <= a_mag;
            mb     <= b_mag;
            a_lat  <= a;
            sa     <= md_op[0] & a[WIDTH-1];
            sb     <= md_op[0] & b[WIDTH-1];
            acc_hi <= '0;
            acc_lo <= md_op[1] ? a_mag : b_mag;
          end else begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (op[1]) begin
            acc_hi <= div_ge ? div_diff : div_t[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (op[1]) begin
            if (mb == '0) begin
              lo  <= '1;
              hi  <= a_lat;
              dbz <= 1'b1;
            end else begin
              lo  <= quo_fix;
              hi  <= rem_fix;
              dbz <= 1'b0;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - WIDTH-generic combinational ALU plus iterative mul/div unit
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);

  logic [WIDTH-1:0] res;
  logic             slt_bit;
  logic             sltu_bit;

  assign slt_bit  = ($signed(bus.a) < $signed(bus.b));
  assign sltu_bit = (bus.a < bus.b);

  always_comb begin
    res = '0;
    case (alu_op_t'(bus.aluop))
      ALU_AND:  res = bus.a & bus.b;
      ALU_OR:   res = bus.a | bus.b;
      ALU_ADD:  res = bus.a + bus.b;
      ALU_XOR:  res = bus.a ^ bus.b;
      ALU_NOR:  res = ~(bus.a | bus.b);
      ALU_SUB:  res = bus.a - bus.b;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, sltu_bit};
      ALU_SLL:  res = bus.b << bus.shamt;
      ALU_SRL:  res = bus.b >> bus.shamt;
      ALU_SRA:  res = $unsigned($signed(bus.b) >>> bus.shamt);
      default:  res = '0;
    endcase
  end

  assign bus.result = res;
  assign bus.zero   = (res == '0);

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .a        (bus.a),
    .b        (bus.b),
    .md_start (bus.md_start),
    .md_op    (bus.md_op),
    .mthi     (bus.mthi),
    .mtlo     (bus.mtlo),
    .busy     (bus.busy),
    .done     (bus.done),
    .dbz      (bus.dbz),
    .hi       (bus.hi),
    .lo       (bus.lo)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv at WIDTH=8
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(8)) bus ();
  alu_muldiv #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string    name;
    logic [7:0] hi;
    logic [7:0] lo;
    logic     dbz;
  } exp_t;

  exp_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_hi"},  bus.hi,  e.hi);
        check({e.name, "_lo"},  bus.lo,  e.lo);
        check({e.name, "_dbz"}, bus.dbz, e.dbz);
      end
    end
  end

  task automatic alu(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] sh, input logic [7:0] exp_res, input logic exp_zero);
    bus.aluop = op; bus.a = a; bus.b = b; bus.shamt = sh;
    #1;
    check({name, "_res"}, bus.result, exp_res);
    check({name, "_zero"}, bus.zero, exp_zero);
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eh, input logic [7:0] el, input logic ed);
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el; e.dbz = ed;
    q.push_back(e);
    bus.md_op = op; bus.a = a; bus.b = b; bus.md_start = 1'b1;
    @(posedge clk); #1;
    bus.md_start = 1'b0;
    check({name, "_busy"}, bus.busy, 1'b1);
  endtask

  task automatic wait_done(input string name, input int exp_lat, input bit pulse_chk);
    int cnt = 0;
    while (bus.done !== 1'b1 && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({name, "_latency"}, cnt, exp_lat);
    check({name, "_idle_on_done"}, bus.busy, 1'b0);
    if (pulse_chk) begin
      @(posedge clk); #1;
      check({name, "_done_pulse"}, bus.done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.a = '0; bus.b = '0; bus.aluop = '0; bus.shamt = '0;
    bus.md_start = 1'b0; bus.md_op = '0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    #12;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_dbz",  bus.dbz,  1'b0);
    check("rst_hi",   bus.hi,   8'h00);
    check("rst_lo",   bus.lo,   8'h00);
    @(posedge clk); #1;
    reset = 1'b1;

    alu("sub_neg",  ALU_SUB,  8'h03, 8'h05, 3'd0, 8'hFE, 1'b0);
    alu("sub_zero", ALU_SUB,  8'h05, 8'h05, 3'd0, 8'h00, 1'b1);
    alu("slt",      ALU_SLT,  8'hFF, 8'h01, 3'd0, 8'h01, 1'b0);
    alu("sltu",     ALU_SLTU, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1);
    alu("sra",      ALU_SRA,  8'h00, 8'h80, 3'd3, 8'hF0, 1'b0);
    alu("srl",      ALU_SRL,  8'h00, 8'h80, 3'd3, 8'h10, 1'b0);
    alu("add_wrap", ALU_ADD,  8'hF0, 8'h20, 3'd0, 8'h10, 1'b0);
    alu("nor",      ALU_NOR,  8'h0F, 8'h30, 3'd0, 8'hC0, 1'b0);
    alu("sll",      ALU_SLL,  8'h00, 8'h81, 3'd1, 8'h02, 1'b0);
    alu("undef_op", 4'b1111,  8'hFF, 8'hFF, 3'd0, 8'h00, 1'b1);

    issue("multu", MD_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    wait_done("multu", 9, 1'b1);
    issue("mult", MD_MULT, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0);
    wait_done("mult", 9, 1'b1);
    issue("div_neg", MD_DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);
    wait_done("div_neg", 9, 1'b1);
    issue("divu", MD_DIVU, 8'h07, 8'h02, 8'h01, 8'h03, 1'b0);
    wait_done("divu", 9, 1'b1);
    issue("div_ovf", MD_DIV, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    wait_done("div_ovf", 9, 1'b1);

    issue("dbz", MD_DIVU, 8'h05, 8'h00, 8'h05, 8'hFF, 1'b1);
    wait_done("dbz", 9, 1'b1);
    issue("mult_keep_dbz", MD_MULTU, 8'h02, 8'h03, 8'h00, 8'h06, 1'b1);
    wait_done("mult_keep_dbz", 9, 1'b1);
    issue("dbz_clear", MD_DIVU, 8'h06, 8'h03, 8'h00, 8'h02, 1'b0);
    wait_done("dbz_clear", 9, 1'b1);

    // Re-start and mtlo during RUN must be dropped.
    issue("ignore_mid", MD_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.md_start = 1'b1; bus.md_op = MD_DIVU; bus.a = 8'h11; bus.b = 8'h22; bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.md_start = 1'b0; bus.mtlo = 1'b0;
    wait_done("ignore_mid", 5, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("hold_hi", bus.hi, 8'hFE);
    check("hold_lo", bus.lo, 8'h01);

    issue("b2b_first", MD_DIVU, 8'h07, 8'h02, 8'h01, 8'h03, 1'b0);
    wait_done("b2b_first", 9, 1'b0);
    issue("b2b_second", MD_MULT, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0);
    wait_done("b2b_second", 9, 1'b1);

    // Abort an op partway through RUN with reset.
    issue("aborted", MD_DIVU, 8'h07, 8'h02, 8'h01, 8'h03, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    void'(q.pop_back());
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hi",   bus.hi,   8'h00);
    check("abort_lo",   bus.lo,   8'h00);
    check("abort_done", bus.done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_still_idle", bus.busy, 1'b0);

    bus.a = 8'h3C; bus.mthi = 1'b1;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    check("mthi_hi", bus.hi, 8'h3C);
    check("mthi_lo", bus.lo, 8'h00);

    bus.a = 8'h5A; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthilo_hi", bus.hi, 8'h5A);
    check("mthilo_lo", bus.lo, 8'h5A);

    bus.mthi = 1'b1;
    issue("start_wins", MD_MULTU, 8'h02, 8'h03, 8'h00, 8'h06, 1'b0);
    bus.mthi = 1'b0;
    check("start_wins_hi_kept", bus.hi, 8'h5A);
    wait_done("start_wins", 9, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
